// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch PC controller.
// Holds the FSM encoding, default widths, reset vector and PC step.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_W_DEF         = 32;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending redirect target register with valid flag.
// Ports: clk_i, rst_ni, wr_i/tgt_i (capture, newest wins),
//        clr_i (clear, dominates write), vld_o, tgt_o.
module pc_redirect_buf #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_i,
  input  logic            clr_i,
  input  logic [PC_W-1:0] tgt_i,
  output logic            vld_o,
  output logic [PC_W-1:0] tgt_o
);

  logic            vld_q, vld_d;
  logic [PC_W-1:0] tgt_q, tgt_d;

  always_comb begin
    vld_d = vld_q;
    tgt_d = tgt_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (wr_i) begin
      vld_d = 1'b1;
      tgt_d = tgt_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      tgt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tgt_q <= tgt_d;
    end
  end

  assign vld_o = vld_q;
  assign tgt_o = tgt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register and I-cache request controller.
// Ports: CLK, RST (async low), PCSrc/PCTarget redirect, CacheReady;
//        PC, PCPlus4, FetchValid, RedirPending, MisalignErr, StallCount.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     PC_W         = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF),
  parameter int unsigned     CNT_W        = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCSrc,
  input  logic [PC_W-1:0]  PCTarget,
  input  logic             CacheReady,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PCPlus4,
  output logic             FetchValid,
  output logic             RedirPending,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] StallCount
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic            run;
  logic            misalign;
  logic            buf_vld;
  logic [PC_W-1:0] buf_tgt;
  logic            buf_wr;
  logic            buf_clr;

  assign run      = (state_q == ST_RUN);
  assign misalign = run & PCSrc & (PCTarget[1:0] != 2'b00);
  assign PCPlus4  = pc_q + PC_W'(PC_INC);

  // Fetch completes only on a good RUN cycle; a bad target freezes PC.
  assign buf_clr = run & (CacheReady | misalign);
  assign buf_wr  = run & PCSrc & ~CacheReady & ~misalign;

  pc_redirect_buf #(
    .PC_W (PC_W)
  ) u_rbuf (
    .clk_i  (CLK),
    .rst_ni (RST),
    .wr_i   (buf_wr),
    .clr_i  (buf_clr),
    .tgt_i  (PCTarget),
    .vld_o  (buf_vld),
    .tgt_o  (buf_tgt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (misalign) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    FetchValid = 1'b0;
    unique case (state_q)
      ST_RUN:  FetchValid = 1'b1;
      default: FetchValid = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (run && CacheReady && !misalign) begin
      priority case (1'b1)
        PCSrc:   pc_d = PCTarget;
        buf_vld: pc_d = buf_tgt;
        default: pc_d = PCPlus4;
      endcase
    end
  end

  always_comb begin
    err_d   = err_q | misalign;
    stall_d = stall_q;
    if (run && !CacheReady && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  assign PC           = pc_q;
  assign RedirPending = buf_vld;
  assign MisalignErr  = err_q;
  assign StallCount   = stall_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl.
// Directed scenarios plus a random run against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam int PW = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PCSrc = 1'b0;
  logic [PW-1:0] PCTarget = '0;
  logic          CacheReady = 1'b0;
  logic [PW-1:0] PC, PCPlus4;
  logic          FetchValid, RedirPending, MisalignErr;
  logic [CW-1:0] StallCount;

  pc_fetch_ctrl #(
    .PC_W         (PW),
    .RESET_VECTOR (32'h0000_0000),
    .CNT_W        (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .CacheReady   (CacheReady),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .FetchValid   (FetchValid),
    .RedirPending (RedirPending),
    .MisalignErr  (MisalignErr),
    .StallCount   (StallCount)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  // Behavioural model
  bit          m_started, m_halted, m_pend, m_err;
  logic [31:0] m_pc, m_ptgt;
  int          m_stall;

  function automatic void m_reset();
    m_started = 0; m_halted = 0; m_pend = 0; m_err = 0;
    m_pc = 32'h0; m_ptgt = 32'h0; m_stall = 0;
  endfunction

  function automatic void m_step(bit src, logic [31:0] tgt, bit rdy);
    if (m_halted) return;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (!rdy && m_stall < (1 << CW) - 1) m_stall++;
    if (src && (tgt % 4 != 0)) begin
      m_halted = 1; m_err = 1; m_pend = 0;
    end else if (rdy) begin
      if (src)         m_pc = tgt;
      else if (m_pend) m_pc = m_ptgt;
      else             m_pc = m_pc + 4;
      m_pend = 0;
    end else if (src) begin
      m_pend = 1; m_ptgt = tgt;
    end
  endfunction

  function automatic bit m_fv();
    return m_started && !m_halted;
  endfunction

  task automatic drive(bit src, logic [31:0] tgt, bit rdy);
    PCSrc = src; PCTarget = tgt; CacheReady = rdy;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST) m_step(PCSrc, PCTarget, CacheReady);
    #1;
  endtask

  task automatic assert_rst();
    RST = 1'b0;
    m_reset();
  endtask

  task automatic reset_run();
    drive(0, 0, 0);
    assert_rst();
    #3;
    RST = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    drive(1, $urandom, 1);
    assert_rst();
    #1;
    checks++; if (PC !== 32'h0) begin errs++; $display("FAIL rst_pc got=%h exp=0", PC); end
    checks++; if (FetchValid !== 1'b0) begin errs++; $display("FAIL rst_fv got=%b exp=0", FetchValid); end
    checks++; if (RedirPending !== 1'b0) begin errs++; $display("FAIL rst_pend got=%b exp=0", RedirPending); end
    checks++; if (MisalignErr !== 1'b0) begin errs++; $display("FAIL rst_err got=%b exp=0", MisalignErr); end
    checks++; if (StallCount !== '0) begin errs++; $display("FAIL rst_stall got=%0d exp=0", StallCount); end
    cycle(); cycle();
    checks++; if (PC !== 32'h0 || FetchValid !== 1'b0) begin
      errs++; $display("FAIL rst_hold pc=%h fv=%b exp pc=0 fv=0", PC, FetchValid);
    end
    drive(1, 32'h0000_0123, 0);
    RST = 1'b1;
    #1;
    checks++; if (FetchValid !== 1'b0) begin errs++; $display("FAIL boot_fv got=%b exp=0", FetchValid); end
    cycle();
    checks++; if (FetchValid !== 1'b1) begin errs++; $display("FAIL run_fv got=%b exp=1", FetchValid); end
    checks++; if (MisalignErr !== 1'b0 || PC !== 32'h0) begin
      errs++; $display("FAIL boot_ignore err=%b pc=%h exp err=0 pc=0", MisalignErr, PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    reset_run();
    drive(0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      exp_pc = 32'(i * 4);
      checks++; if (PC !== exp_pc || PC !== m_pc) begin
        errs++; $display("FAIL seq_pc%0d got=%h exp=%h", i, PC, exp_pc);
      end
    end
    checks++; if (PCPlus4 !== 32'h14) begin errs++; $display("FAIL seq_plus4 got=%h exp=14", PCPlus4); end
  endtask

  task automatic test_redirect();
    drive(1, 32'h0000_AAFC, 1);
    cycle();
    checks++; if (PC !== 32'h0000_AAFC) begin errs++; $display("FAIL redir1 got=%h exp=0000aafc", PC); end
    drive(1, 32'h1999_AAFC, 1);
    cycle();
    checks++; if (PC !== 32'h1999_AAFC) begin errs++; $display("FAIL redir2 got=%h exp=1999aafc", PC); end
    checks++; if (RedirPending !== 1'b0) begin errs++; $display("FAIL redir_pend got=%b exp=0", RedirPending); end
    checks++; if (PCPlus4 !== 32'h1999_AB00) begin errs++; $display("FAIL redir_plus4 got=%h exp=1999ab00", PCPlus4); end
  endtask

  task automatic test_stall();
    reset_run();
    drive(1, 32'h0850_AACC, 0);
    cycle();
    drive(0, 0, 0);
    cycle(); cycle();
    checks++; if (PC !== 32'h0) begin errs++; $display("FAIL stall_pc got=%h exp=0", PC); end
    checks++; if (RedirPending !== 1'b1) begin errs++; $display("FAIL stall_pend got=%b exp=1", RedirPending); end
    checks++; if (StallCount !== 4'd3) begin errs++; $display("FAIL stall_cnt got=%0d exp=3", StallCount); end
    drive(0, 0, 1);
    cycle();
    checks++; if (PC !== 32'h0850_AACC) begin errs++; $display("FAIL stall_redir got=%h exp=0850aacc", PC); end
    checks++; if (RedirPending !== 1'b0) begin errs++; $display("FAIL stall_pend_clr got=%b exp=0", RedirPending); end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h100, 0); cycle();
    drive(1, 32'h200, 0); cycle();
    drive(0, 0, 0); cycle();
    drive(0, 0, 1); cycle();
    checks++; if (PC !== 32'h200) begin errs++; $display("FAIL b2b_newest got=%h exp=200", PC); end
    drive(1, 32'h300, 0); cycle();
    drive(1, 32'h400, 1); cycle();
    checks++; if (PC !== 32'h400 || RedirPending !== 1'b0) begin
      errs++; $display("FAIL b2b_override pc=%h pend=%b exp pc=400 pend=0", PC, RedirPending);
    end
    drive(0, 0, 1); cycle();
    checks++; if (PC !== 32'h404) begin errs++; $display("FAIL b2b_discard got=%h exp=404", PC); end
  endtask

  task automatic test_stall_sat();
    drive(0, 0, 0);
    for (int i = 0; i < 20; i++) cycle();
    checks++; if (StallCount !== 4'hF || int'(StallCount) != m_stall) begin
      errs++; $display("FAIL stall_sat got=%0d exp=15", StallCount);
    end
  endtask

  task automatic test_wrap();
    reset_run();
    drive(1, 32'hFFFF_FFFC, 1); cycle();
    checks++; if (PCPlus4 !== 32'h0) begin errs++; $display("FAIL wrap_plus4 got=%h exp=0", PCPlus4); end
    drive(0, 0, 1); cycle();
    checks++; if (PC !== 32'h0) begin errs++; $display("FAIL wrap_pc got=%h exp=0", PC); end
    drive(1, 32'h500, 0); cycle();
    drive(0, 0, 0);
    #2;
    assert_rst();
    #1;
    checks++; if (PC !== 32'h0 || FetchValid !== 1'b0 || RedirPending !== 1'b0 ||
                  MisalignErr !== 1'b0 || StallCount !== '0) begin
      errs++; $display("FAIL midrst pc=%h fv=%b pend=%b err=%b cnt=%0d exp all 0",
                       PC, FetchValid, RedirPending, MisalignErr, StallCount);
    end
    #2;
    RST = 1'b1;
    cycle();
    drive(0, 0, 1); cycle();
    checks++; if (PC !== 32'h4) begin errs++; $display("FAIL midrst_noredir got=%h exp=4", PC); end
  endtask

  task automatic test_misalign();
    logic [CW-1:0] cnt;
    reset_run();
    drive(1, 32'h6395_1895, 1); cycle();
    checks++; if (MisalignErr !== 1'b1) begin errs++; $display("FAIL mis_err got=%b exp=1", MisalignErr); end
    checks++; if (FetchValid !== 1'b0) begin errs++; $display("FAIL mis_fv got=%b exp=0", FetchValid); end
    cnt = StallCount;
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
      cycle();
      checks++; if (PC !== 32'h0 || FetchValid !== 1'b0 || MisalignErr !== 1'b1 ||
                    StallCount !== cnt || RedirPending !== 1'b0) begin
        errs++; $display("FAIL mis_frozen pc=%h fv=%b err=%b exp pc=0 fv=0 err=1", PC, FetchValid, MisalignErr);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    reset_run();
    for (int i = 0; i < 600; i++) begin
      t = $urandom;
      if ($urandom_range(0, 39) != 0) t[1:0] = 2'b00;
      drive(($urandom_range(0, 3) == 0), t, ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 79) == 0) begin
        assert_rst();
        #2;
        RST = 1'b1;
      end
      cycle();
      checks++; if (PC !== m_pc || PCPlus4 !== m_pc + 32'd4 || FetchValid !== m_fv() ||
                    RedirPending !== m_pend || MisalignErr !== m_err ||
                    int'(StallCount) != m_stall) begin
        errs++;
        $display("FAIL rand%0d pc=%h/%h fv=%b/%b pend=%b/%b err=%b/%b cnt=%0d/%0d",
                 i, PC, m_pc, FetchValid, m_fv(), RedirPending, m_pend,
                 MisalignErr, m_err, StallCount, m_stall);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_back_to_back();
    test_stall_sat();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
